// File: rtl/clk_div_phase_gen.sv
// Programmable divided clock with phase offset and a phase-0 reference tick.
// Config is double-buffered: loads land in pending regs and are promoted only at a period boundary.
module clk_div_phase_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] phase_off,
  output logic             clk_out,
  output logic             ref_tick,
  output logic             rise,
  output logic             locked,
  output logic             cfg_err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] ref_cnt, cnt_nx, k_adv;
  logic [CNT_W-1:0] act_n, act_p, pend_n, pend_p, use_n, use_p;
  logic             act_v, pend_v;
  logic             load_ok, wrap, promote_pend, promote_load, out_en, wave_nx;

  // Level of the generated clock at count k: ((k - p) mod n) < n/2, computed without overflow.
  function automatic logic wave_at(input logic [CNT_W-1:0] k,
                                   input logic [CNT_W-1:0] n,
                                   input logic [CNT_W-1:0] p);
    logic [CNT_W:0] d;
    if (k >= p) d = {1'b0, k} - {1'b0, p};
    else        d = {1'b0, k} + {1'b0, n} - {1'b0, p};
    return d < {2'b00, n[CNT_W-1:1]};
  endfunction

  assign load_ok = load && (div_ratio[CNT_W-1:1] != '0) && (phase_off < div_ratio);
  assign wrap    = (ref_cnt == act_n - CNT_W'(1));
  assign k_adv   = wrap ? '0 : ref_cnt + CNT_W'(1);

  always_comb begin
    state_nx     = state;
    cnt_nx       = '0;
    use_n        = act_n;
    use_p        = act_p;
    promote_pend = 1'b0;
    promote_load = 1'b0;
    out_en       = 1'b0;
    case (state)
      IDLE: begin
        if (en && (load_ok || pend_v || act_v)) begin
          state_nx = RUN;
          out_en   = 1'b1;
          // A load on the start edge is used directly, bypassing the pending regs.
          if (load_ok) begin
            promote_load = 1'b1;
            use_n        = div_ratio;
            use_p        = phase_off;
          end else if (pend_v) begin
            promote_pend = 1'b1;
            use_n        = pend_n;
            use_p        = pend_p;
          end
        end
      end
      RUN: begin
        cnt_nx = k_adv;
        out_en = 1'b1;
        if (wrap && pend_v) begin
          promote_pend = 1'b1;
          use_n        = pend_n;
          use_p        = pend_p;
        end
        if (!en) state_nx = DRAIN;
      end
      DRAIN: begin
        cnt_nx = k_adv;
        out_en = 1'b1;
        if (en) begin
          state_nx = RUN;
        end else if (!wave_at(k_adv, act_n, act_p)) begin
          // Stop only once the clock would be low, so a high phase is never cut short.
          state_nx = IDLE;
          cnt_nx   = '0;
          out_en   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign wave_nx = wave_at(cnt_nx, use_n, use_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ref_cnt  <= '0;
      act_n    <= '0;
      act_p    <= '0;
      act_v    <= 1'b0;
      pend_n   <= '0;
      pend_p   <= '0;
      pend_v   <= 1'b0;
      clk_out  <= 1'b0;
      ref_tick <= 1'b0;
      rise     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      ref_cnt <= cnt_nx;
      if (promote_load || promote_pend) begin
        act_n <= use_n;
        act_p <= use_p;
        act_v <= 1'b1;
      end
      if (load_ok && !promote_load) begin
        pend_n <= div_ratio;
        pend_p <= phase_off;
        pend_v <= 1'b1;
      end else if (promote_pend || promote_load) begin
        pend_v <= 1'b0;
      end
      clk_out  <= out_en & wave_nx;
      ref_tick <= out_en & (cnt_nx == '0);
      rise     <= out_en & (cnt_nx == use_p);
      cfg_err  <= load & ~load_ok;
    end
  end

  assign locked    = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_clk_div_phase_gen.sv
// Bench for clk_div_phase_gen: directed scenarios plus random stimulus, all checked
// against a cycle-level behavioural model of the divider.
module tb_clk_div_phase_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic [7:0] phase_off = 8'd0;
  logic       clk_out, ref_tick, rise, locked, cfg_err;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;

  // behavioural model: 0 = stopped, 1 = running, 2 = finishing a high phase
  int m_st, m_k, m_n, m_p, m_pn, m_pp;
  bit m_av, m_pv;
  bit e_clk, e_ref, e_rise, e_err;

  clk_div_phase_gen #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .div_ratio(div_ratio), .phase_off(phase_off),
    .clk_out(clk_out), .ref_tick(ref_tick), .rise(rise),
    .locked(locked), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic bit f_clk(int k, int n, int p);
    return ((k - p + n) % n) < (n / 2);
  endfunction

  function automatic logic [4:0] exp_vec();
    return {e_clk, e_ref, e_rise, (m_st == 1), e_err};
  endfunction

  task automatic model_edge();
    bit lok, go, used;
    int dn, dp;
    if (rst) begin
      m_st = 0; m_k = 0; m_n = 0; m_p = 0; m_pn = 0; m_pp = 0;
      m_av = 0; m_pv = 0;
      e_clk = 0; e_ref = 0; e_rise = 0; e_err = 0;
    end else begin
      dn = int'(div_ratio);
      dp = int'(phase_off);
      lok = load && dn >= 2 && dp < dn;
      e_err = load && !lok;
      go = 0;
      used = 0;
      case (m_st)
        0: if (en && (lok || m_pv || m_av)) begin
             if (lok) begin m_n = dn; m_p = dp; used = 1; m_pv = 0; end
             else if (m_pv) begin m_n = m_pn; m_p = m_pp; m_pv = 0; end
             m_av = 1; m_st = 1; m_k = 0; go = 1;
           end
        1: begin
             m_k = (m_k + 1) % m_n;
             if (m_k == 0 && m_pv) begin m_n = m_pn; m_p = m_pp; m_pv = 0; end
             if (!en) m_st = 2;
             go = 1;
           end
        default: begin
             m_k = (m_k + 1) % m_n;
             if (en) begin m_st = 1; go = 1; end
             else if (!f_clk(m_k, m_n, m_p)) begin m_st = 0; m_k = 0; go = 0; end
             else go = 1;
           end
      endcase
      if (lok && !used) begin m_pn = dn; m_pp = dp; m_pv = 1; end
      e_clk  = go && f_clk(m_k, m_n, m_p);
      e_ref  = go && (m_k == 0);
      e_rise = go && (m_k == m_p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic start_cfg(input int n, input int p);
    rst = 1; en = 0; load = 0;
    step();
    rst = 0;
    div_ratio = 8'(n); phase_off = 8'(p); load = 1; en = 1;
    step();
    load = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; load = 0;
    step();
    step();
    total++;
    if ({clk_out, ref_tick, rise, locked, cfg_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", {clk_out, ref_tick, rise, locked, cfg_err}, 5'b0);
    end
    rst = 0;
  endtask

  task automatic test_n4_p0();
    logic [11:0] pat;
    pat = '0;
    start_cfg(4, 0);
    total++;
    if ({clk_out, ref_tick, rise, locked, cfg_err} !== 5'b11110) begin
      bad++;
      $display("FAIL n4_first_cycle got=%b exp=%b", {clk_out, ref_tick, rise, locked, cfg_err}, 5'b11110);
    end
    for (int i = 0; i < 12; i++) begin
      pat = {pat[10:0], clk_out};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL n4_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      step();
    end
    total++;
    if (pat !== 12'b110011001100) begin
      bad++;
      $display("FAIL n4_wave got=%b exp=%b", pat, 12'b110011001100);
    end
  endtask

  task automatic test_n5_p2();
    logic [9:0] cp, rp, sp;
    cp = '0; rp = '0; sp = '0;
    start_cfg(5, 2);
    for (int i = 0; i < 10; i++) begin
      cp = {cp[8:0], clk_out};
      rp = {rp[8:0], ref_tick};
      sp = {sp[8:0], rise};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL n5_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      step();
    end
    total++;
    if ({cp, rp, sp} !== {10'b0011000110, 10'b1000010000, 10'b0010000100}) begin
      bad++;
      $display("FAIL n5_wave got=%b/%b/%b exp=0011000110/1000010000/0010000100", cp, rp, sp);
    end
  endtask

  task automatic test_reload_mid_period();
    logic [7:0] cp, rp;
    cp = '0; rp = '0;
    start_cfg(4, 0);
    step();
    div_ratio = 8'd6; phase_off = 8'd1; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 8; i++) begin
      cp = {cp[6:0], clk_out};
      rp = {rp[6:0], ref_tick};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL reload_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      step();
    end
    total++;
    if ({cp, rp} !== {8'b00011100, 8'b00100000}) begin
      bad++;
      $display("FAIL reload_wave got=%b/%b exp=00011100/00100000", cp, rp);
    end
  endtask

  task automatic test_load_at_wrap();
    logic [9:0] cp;
    cp = '0;
    start_cfg(4, 0);
    step(); step(); step();
    div_ratio = 8'd6; phase_off = 8'd1; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 10; i++) begin
      cp = {cp[8:0], clk_out};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL wrap_load_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      step();
    end
    total++;
    if (cp !== 10'b1100011100) begin
      bad++;
      $display("FAIL wrap_load_wave got=%b exp=%b", cp, 10'b1100011100);
    end
  endtask

  task automatic test_cfg_err();
    logic [7:0] cp;
    cp = '0;
    start_cfg(4, 0);
    div_ratio = 8'd1; phase_off = 8'd0; load = 1;
    step();
    load = 0;
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL cfg_err_n1 got=%b exp=1", cfg_err);
    end
    div_ratio = 8'd4; phase_off = 8'd4; load = 1;
    step();
    load = 0;
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL cfg_err_p_eq_n got=%b exp=1", cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      cp = {cp[6:0], clk_out};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL cfg_err_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      step();
    end
    total++;
    if (cp !== 8'b00110011) begin
      bad++;
      $display("FAIL cfg_err_wave got=%b exp=%b", cp, 8'b00110011);
    end
  endtask

  task automatic test_drain();
    logic [9:0] cp, rp;
    cp = '0; rp = '0;
    start_cfg(6, 0);
    for (int i = 0; i < 10; i++) begin
      cp = {cp[8:0], clk_out};
      rp = {rp[8:0], ref_tick};
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL drain_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
      if (i == 1) en = 0;
      step();
    end
    total++;
    if ({cp, rp} !== {10'b1110000000, 10'b1000000000}) begin
      bad++;
      $display("FAIL drain_wave got=%b/%b exp=1110000000/1000000000", cp, rp);
    end
  endtask

  task automatic test_rst_mid_high();
    start_cfg(4, 0);
    step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== 5'b0) begin
        bad++;
        $display("FAIL rst_mid_idle cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, 5'b0);
      end
      step();
    end
  endtask

  task automatic test_random();
    rst = 1; en = 0; load = 0;
    step();
    rst = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 19) == 0) en = ~en;
      load = ($urandom_range(0, 9) == 0);
      div_ratio = 8'($urandom_range(0, 12));
      phase_off = 8'($urandom_range(0, 12));
      step();
      total++;
      if ({clk_out, ref_tick, rise, locked, cfg_err} !== exp_vec()) begin
        bad++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {clk_out, ref_tick, rise, locked, cfg_err}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_n4_p0();
    test_n5_p2();
    test_reload_mid_period();
    test_load_at_wrap();
    test_cfg_err();
    test_drain();
    test_rst_mid_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
